// File: rtl/t_alias_resolver_if.sv
// Request/response bundle for the alias resolver: union declarations, root queries
// and the status outputs.
interface t_alias_resolver_if #(
   parameter int unsigned IDW  = 3,
   parameter int unsigned CNTW = 8
);
   logic            union_valid;
   logic            union_ready;
   logic [IDW-1:0]  union_a;
   logic [IDW-1:0]  union_b;
   logic            union_done;
   logic            union_redundant;
   logic            query_valid;
   logic            query_ready;
   logic [IDW-1:0]  query_id;
   logic            resp_valid;
   logic [IDW-1:0]  resp_root;
   logic [CNTW-1:0] redundant_count;
   logic            busy;

   modport master (
      output union_valid, union_a, union_b, query_valid, query_id,
      input  union_ready, union_done, union_redundant, query_ready,
             resp_valid, resp_root, redundant_count, busy
   );

   modport slave (
      input  union_valid, union_a, union_b, query_valid, query_id,
      output union_ready, union_done, union_redundant, query_ready,
             resp_valid, resp_root, redundant_count, busy
   );
endinterface

// File: rtl/t_alias_resolver.sv
// Sequential union-find over NNETS net IDs; roots are kept at the minimum index of
// each class so query answers do not depend on declaration order.
module t_alias_resolver #(
   parameter int unsigned NNETS = 8,
   parameter int unsigned IDW   = $clog2(NNETS),
   parameter int unsigned CNTW  = 8
) (
   input  logic               clk,
   input  logic               rst,
   t_alias_resolver_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, FA, FB, LINK, DONE, QF} state_t;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   state_t          state, state_n;
   logic [IDW-1:0]  parent [NNETS];
   logic [IDW-1:0]  cur, cur_n;
   logic [IDW-1:0]  b_q, b_n;
   logic [IDW-1:0]  ra, ra_n;
   logic [IDW-1:0]  rb, rb_n;
   logic            red_q, red_n;
   logic            link_we;
   logic [IDW-1:0]  link_hi, link_lo;
   logic [IDW-1:0]  pcur;

   logic            union_ready_q, union_ready_n;
   logic            busy_q, busy_n;
   logic            done_q, done_n;
   logic            ured_q, ured_n;
   logic            pend_q, pend_n;
   logic            rvalid_q;
   logic [IDW-1:0]  root_q, root_n;
   logic [CNTW-1:0] cnt_q, cnt_n;

   // Out-of-range IDs wrap modulo NNETS (at most one subtraction is ever needed).
   function automatic logic [IDW-1:0] wrap(input logic [IDW-1:0] x);
      if (32'(x) >= NNETS) return IDW'(32'(x) - NNETS);
      return x;
   endfunction

   assign pcur    = parent[cur];
   assign link_hi = (ra > rb) ? ra : rb;
   assign link_lo = (ra > rb) ? rb : ra;

   // Next-state and registered-output computation
   always_comb begin
      state_n = state;
      cur_n   = cur;
      b_n     = b_q;
      ra_n    = ra;
      rb_n    = rb;
      red_n   = red_q;
      link_we = 1'b0;
      done_n  = 1'b0;
      ured_n  = 1'b0;
      pend_n  = 1'b0;
      root_n  = root_q;
      cnt_n   = cnt_q;
      case (state)
         IDLE: begin
            if (bus.union_valid) begin
               state_n = FA;
               cur_n   = wrap(bus.union_a);
               b_n     = wrap(bus.union_b);
            end else if (bus.query_valid) begin
               state_n = QF;
               cur_n   = wrap(bus.query_id);
            end
         end
         FA: begin
            if (pcur == cur) begin
               ra_n    = cur;
               cur_n   = b_q;
               state_n = FB;
            end else begin
               cur_n = pcur;
            end
         end
         FB: begin
            if (pcur == cur) begin
               rb_n    = cur;
               state_n = LINK;
            end else begin
               cur_n = pcur;
            end
         end
         LINK: begin
            red_n   = (ra == rb);
            link_we = (ra != rb);
            state_n = DONE;
         end
         DONE: begin
            done_n  = 1'b1;
            ured_n  = red_q;
            if (red_q && (cnt_q != CNT_MAX)) cnt_n = cnt_q + CNTW'(1);
            state_n = IDLE;
         end
         QF: begin
            if (pcur == cur) begin
               root_n  = cur;
               pend_n  = 1'b1;
               state_n = IDLE;
            end else begin
               cur_n = pcur;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n        = (state_n != IDLE);
      union_ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cur           <= '0;
         b_q           <= '0;
         ra            <= '0;
         rb            <= '0;
         red_q         <= 1'b0;
         union_ready_q <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         ured_q        <= 1'b0;
         pend_q        <= 1'b0;
         rvalid_q      <= 1'b0;
         root_q        <= '0;
         cnt_q         <= '0;
      end else begin
         state         <= state_n;
         cur           <= cur_n;
         b_q           <= b_n;
         ra            <= ra_n;
         rb            <= rb_n;
         red_q         <= red_n;
         union_ready_q <= union_ready_n;
         busy_q        <= busy_n;
         done_q        <= done_n;
         ured_q        <= ured_n;
         pend_q        <= pend_n;
         rvalid_q      <= pend_q;
         root_q        <= root_n;
         cnt_q         <= cnt_n;
      end
   end

   // Parent table: identity on reset, so an aborted union leaves no partial link.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NNETS; i++) parent[i] <= IDW'(i);
      end else if (link_we) begin
         parent[link_hi] <= link_lo;
      end
   end

   assign bus.union_ready     = union_ready_q;
   assign bus.query_ready     = union_ready_q & ~bus.union_valid;
   assign bus.union_done      = done_q;
   assign bus.union_redundant = ured_q;
   assign bus.resp_valid      = rvalid_q;
   assign bus.resp_root       = root_q;
   assign bus.redundant_count = cnt_q;
   assign bus.busy            = busy_q;

endmodule
